// File: rtl/instr_field_pipe.sv
// instr_field_pipe: 2-entry skid FIFO that splits instruction words into opcode/register/funct/immediate fields.
// Macro INSTR_FIELD_PIPE_SIGNEXT_EN selects sign-extension of imm_ext (zero-extension when undefined).
module instr_field_pipe #(
   parameter int INSTR_W = 16,
   parameter int OPC_W   = 4,
   parameter int REG_W   = 3,
   parameter int FUNCT_W = 3,
   parameter int DATA_W  = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [INSTR_W-1:0]         in_instr,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [OPC_W-1:0]           opcode,
   output logic [REG_W-1:0]           rs,
   output logic [REG_W-1:0]           rt,
   output logic [REG_W-1:0]           rd,
   output logic [FUNCT_W-1:0]         funct,
   output logic [REG_W+FUNCT_W-1:0]   immed,
   output logic [DATA_W-1:0]          imm_ext,
   output logic [1:0]                 count
);

   localparam int IMM_W = REG_W + FUNCT_W;

   localparam logic [1:0] EMPTY = 2'd0;
   localparam logic [1:0] ONE   = 2'd1;
   localparam logic [1:0] FULL  = 2'd2;

   generate
      if (INSTR_W != OPC_W + 3*REG_W + FUNCT_W) begin : g_bad_instr_w
         $error("instr_field_pipe: INSTR_W must equal OPC_W+3*REG_W+FUNCT_W");
      end
      if (DATA_W < IMM_W) begin : g_bad_data_w
         $error("instr_field_pipe: DATA_W must be >= REG_W+FUNCT_W");
      end
   endgenerate

   // Handshake: a word transfers on any edge where valid && ready are both high.
   // in_ready depends only on registered state, never on out_ready.
   logic [1:0]          state;
   logic [INSTR_W-1:0]  head;
   logic [INSTR_W-1:0]  second;
   logic                push;
   logic                pop;

   assign in_ready  = (state != FULL);
   assign out_valid = (state != EMPTY);
   assign count     = state;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= EMPTY;
         head   <= '0;
         second <= '0;
      end else if (flush) begin
         state  <= EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (push) begin
                  head  <= in_instr;
                  state <= ONE;
               end
            end
            ONE: begin
               if (push && pop) begin
                  head   <= in_instr;
               end else if (push) begin
                  second <= in_instr;
                  state  <= FULL;
               end else if (pop) begin
                  state  <= EMPTY;
               end
            end
            FULL: begin
               if (pop) begin
                  head  <= second;
                  state <= ONE;
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end

   // Every field is a fixed slice of the head register.
   assign opcode = head[INSTR_W-1 -: OPC_W];
   assign rs     = head[INSTR_W-OPC_W-1 -: REG_W];
   assign rt     = head[INSTR_W-OPC_W-REG_W-1 -: REG_W];
   assign rd     = head[FUNCT_W +: REG_W];
   assign funct  = head[FUNCT_W-1:0];
   assign immed  = head[IMM_W-1:0];

`ifdef INSTR_FIELD_PIPE_SIGNEXT_EN
   assign imm_ext = DATA_W'($signed(immed));
`else
   assign imm_ext = DATA_W'(immed);
`endif

endmodule

// File: tb/tb_instr_field_pipe.sv
// Directed bench for instr_field_pipe: reset, field split, extension, backpressure, push+pop, flush, mid-run reset.
module tb_instr_field_pipe;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_instr;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  opcode;
   logic [2:0]  rs;
   logic [2:0]  rt;
   logic [2:0]  rd;
   logic [2:0]  funct;
   logic [5:0]  immed;
   logic [15:0] imm_ext;
   logic [1:0]  count;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   instr_field_pipe dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_instr  (in_instr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .opcode    (opcode),
      .rs        (rs),
      .rt        (rt),
      .rd        (rd),
      .funct     (funct),
      .immed     (immed),
      .imm_ext   (imm_ext),
      .count     (count)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] head_word();
      return {opcode, rs, rt, rd, funct};
   endfunction

   initial begin
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b1;
      step(); step();
      check("rst_count",   32'(count),     32'd0);
      check("rst_ovalid",  32'(out_valid), 32'd0);
      check("rst_iready",  32'(in_ready),  32'd1);
      check("rst_word",    32'(head_word()), 32'h0);
      check("rst_immext",  32'(imm_ext),   32'h0);

      // basic split, pushed in the first cycle after reset
      reset = 1'b0; in_valid = 1'b1; in_instr = 16'hA5C7;
      step();
      in_valid = 1'b0;
      check("split_ovalid", 32'(out_valid), 32'd1);
      check("split_count",  32'(count),     32'd1);
      check("split_opcode", 32'(opcode),    32'hA);
      check("split_rs",     32'(rs),        32'd2);
      check("split_rt",     32'(rt),        32'd7);
      check("split_rd",     32'(rd),        32'd0);
      check("split_funct",  32'(funct),     32'd7);
      check("split_immed",  32'(immed),     32'h07);
      check("split_immext", 32'(imm_ext),   32'h0007);
      step();
      check("split_drain",  32'(count),     32'd0);

      // extension of a negative immediate
      in_valid = 1'b1; in_instr = 16'h003F;
      step();
      in_valid = 1'b0;
      check("ext_immed", 32'(immed), 32'h3F);
`ifdef INSTR_FIELD_PIPE_SIGNEXT_EN
      check("ext_immext", 32'(imm_ext), 32'hFFFF);
`else
      check("ext_immext", 32'(imm_ext), 32'h003F);
`endif
      step();
      check("ext_drain", 32'(count), 32'd0);

      // backpressure: two pushes fill, third held upstream
      out_ready = 1'b0; in_valid = 1'b1; in_instr = 16'h1234;
      step();
      check("bp_count1",  32'(count),    32'd1);
      check("bp_iready1", 32'(in_ready), 32'd1);
      in_instr = 16'h5678;
      step();
      check("bp_count2",  32'(count),    32'd2);
      check("bp_iready2", 32'(in_ready), 32'd0);
      check("bp_head1",   32'(head_word()), 32'h1234);
      in_instr = 16'h9ABC;
      step();
      check("bp_hold_count", 32'(count),       32'd2);
      check("bp_hold_head",  32'(head_word()), 32'h1234);
      out_ready = 1'b1;
      step();
      check("bp_pop_count", 32'(count),       32'd1);
      check("bp_pop_head",  32'(head_word()), 32'h5678);
      check("bp_pop_iready", 32'(in_ready),   32'd1);
      // ONE with push and pop together: head becomes the new word
      step();
      in_valid = 1'b0;
      check("pp_count", 32'(count),       32'd1);
      check("pp_head",  32'(head_word()), 32'h9ABC);
      step();
      check("pp_drain_count",  32'(count),     32'd0);
      check("pp_drain_ovalid", 32'(out_valid), 32'd0);

      // flush while FULL with a word offered
      out_ready = 1'b0; in_valid = 1'b1; in_instr = 16'h1111;
      step();
      in_instr = 16'h2222;
      step();
      check("fl_full", 32'(count), 32'd2);
      flush = 1'b1; in_instr = 16'h3333;
      step();
      flush = 1'b0; in_valid = 1'b0;
      check("fl_count",  32'(count),     32'd0);
      check("fl_ovalid", 32'(out_valid), 32'd0);
      check("fl_iready", 32'(in_ready),  32'd1);
      out_ready = 1'b1;
      step();
      check("fl_stay_empty", 32'(count), 32'd0);
      in_valid = 1'b1; in_instr = 16'h4444;
      step();
      in_valid = 1'b0;
      check("fl_next_head", 32'(head_word()), 32'h4444);
      step();
      check("fl_drain", 32'(count), 32'd0);

      // reset mid-operation from FULL
      out_ready = 1'b0; in_valid = 1'b1; in_instr = 16'h5555;
      step();
      in_instr = 16'h6666;
      step();
      check("mr_full", 32'(count), 32'd2);
      reset = 1'b1; in_instr = 16'h7777;
      step();
      reset = 1'b0;
      check("mr_count",  32'(count),       32'd0);
      check("mr_ovalid", 32'(out_valid),   32'd0);
      check("mr_iready", 32'(in_ready),    32'd1);
      check("mr_word",   32'(head_word()), 32'h0);
      check("mr_immext", 32'(imm_ext),     32'h0);
      step();
      in_valid = 1'b0;
      check("mr_push_count", 32'(count),       32'd1);
      check("mr_push_head",  32'(head_word()), 32'h7777);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/instr_field_pipe.md
INSTR_FIELD_PIPE -- requirements
Module: instr_field_pipe

Interface
REQ-001 SHALL provide parameter INSTR_W, default 16, giving the instruction word width.
REQ-002 SHALL provide parameter OPC_W, default 4, giving the opcode field width (MSBs).
REQ-003 SHALL provide parameter REG_W, default 3, giving the width of each rs/rt/rd register field.
REQ-004 SHALL provide parameter FUNCT_W, default 3, giving the funct field width (LSBs).
REQ-005 SHALL provide parameter DATA_W, default 16, giving the extended immediate width.
REQ-006 SHALL use one clock and a synchronous, active-high reset; both ports are listed first below.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-008 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-009 SHALL have port flush, input, 1 bit: discard all buffered instructions.
REQ-010 SHALL have port in_valid, input, 1 bit: upstream instruction valid.
REQ-011 SHALL have port in_ready, output, 1 bit: block can accept an instruction.
REQ-012 SHALL have port in_instr, input, INSTR_W bits: raw instruction word.
REQ-013 SHALL have port out_valid, output, 1 bit: head entry valid.
REQ-014 SHALL have port out_ready, input, 1 bit: downstream accepts the head entry.
REQ-015 SHALL have port opcode, output, OPC_W bits: in_instr[INSTR_W-1 -: OPC_W] of the head entry.
REQ-016 SHALL have ports rs, rt and rd, outputs, REG_W bits each: the next three REG_W fields below the opcode, in that order.
REQ-017 SHALL have port funct, output, FUNCT_W bits: the low FUNCT_W bits of the head entry.
REQ-018 SHALL have port immed, output, REG_W+FUNCT_W bits: the low rd+funct bits of the head entry.
REQ-019 SHALL have port imm_ext, output, DATA_W bits: immed extended to DATA_W bits (see Configuration).
REQ-020 SHALL have port count, output, 2 bits: current occupancy, 0..2.

Function
REQ-021 SHALL require INSTR_W == OPC_W+3*REG_W+FUNCT_W and DATA_W >= REG_W+FUNCT_W; elaboration SHALL fail otherwise.
REQ-022 SHALL implement a 2-entry FIFO skid buffer with states EMPTY (count 0), ONE (count 1) and FULL (count 2).
REQ-023 SHALL accept (push) an instruction when in_valid && in_ready, and release (pop) the head entry when out_valid && out_ready.
REQ-024 SHALL drive in_ready = (count != 2), decoded directly from registered state with no combinational path from out_ready.
REQ-025 SHALL drive out_valid = (count != 0), and SHALL drive all field outputs from the head entry register only.
REQ-026 SHALL give a latency of 1 cycle: an instruction pushed into EMPTY appears on the outputs the next cycle.
REQ-027 SHALL make these state transitions:
  - EMPTY: push -> ONE.
  - ONE: push only -> FULL; pop only -> EMPTY; push and pop together -> ONE, with the new word becoming head.
  - FULL: pop -> ONE, with the second entry becoming head; no push is possible.
REQ-028 SHALL preserve arrival order; no entry is ever dropped or duplicated.
REQ-029 SHALL, on flush, set count to 0 next cycle; flush has priority over a simultaneous push or pop, and a word offered in the flush cycle is discarded.
REQ-030 SHALL hold the field outputs stable while out_valid && !out_ready.
REQ-031 SHALL leave field outputs unspecified while out_valid is 0, and SHALL NOT change the head entry when no pop occurs.

Reset
REQ-032 SHALL, while reset is high at a clock edge, set count to 0, out_valid to 0, in_ready to 1, and all field and data registers to 0.
REQ-033 SHALL give reset priority over flush, push and pop; an instruction in flight during reset is lost.
REQ-034 SHALL allow a push in the first cycle after reset is deasserted.

Configuration
REQ-035 SHALL use macro INSTR_FIELD_PIPE_SIGNEXT_EN to select the immediate extension mode.
REQ-036 SHALL, when INSTR_FIELD_PIPE_SIGNEXT_EN is defined, produce imm_ext as immed sign-extended from bit REG_W+FUNCT_W-1.
REQ-037 SHALL, when INSTR_FIELD_PIPE_SIGNEXT_EN is undefined, produce imm_ext as immed zero-extended; all other behaviour is identical in both modes.

Verification
REQ-038 SHALL cover basic split: defaults, push 16'hA5C7 into EMPTY with out_ready=1 -> next cycle out_valid=1, opcode=4'hA, rs=3'b010, rt=3'b111, rd=3'b000, funct=3'b111, immed=6'h07.
REQ-039 SHALL cover sign extension: push 16'h003F -> imm_ext=16'hFFFF with the macro defined, 16'h003F without it.
REQ-040 SHALL cover backpressure: out_ready=0 while pushing 3 words -> count=2 and in_ready=0 after two pushes, the third is held upstream; then out_ready=1 -> words emerge in order, one per cycle.
REQ-041 SHALL cover simultaneous events: in ONE with push and pop in the same cycle -> count stays 1 and the head is the new word.
REQ-042 SHALL cover flush: in FULL, flush=1 with in_valid=1 -> next cycle count=0, out_valid=0, in_ready=1, and the offered word is never output.
REQ-043 SHALL cover reset mid-operation: count=2, then reset=1 for one cycle -> count=0, out_valid=0, all fields 0; a push on the next cycle is accepted.
